seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receiving end of the team's 7-segment display path: samples a time-multiplexed segment bus (one digit at a time) and recovers the BCD digits being shown. Each segment pattern is mapped back to a BCD nibble. Patterns are collected into a full frame (one sample per digit position). A new frame is published only after it has been stable for a programmable number of consecutive frames. The block is used as a display-observer/self-check next to multiplexed 7-segment drivers.

## Interface

Parameters:
- `NDIG`, default 4: number of multiplexed digit positions (1..8).
- `STABLE`, default 2: consecutive identical complete frames required before publishing (1..15).

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `seg`  input  7: segment pattern, active-high, bit order abcdefg (`seg[6]`=a … `seg[0]`=g).
- `dig_sel`  input  NDIG: digit enable, one-hot; bit i selects digit i (digit 0 = least significant).
- `strobe`  input  1: `seg`/`dig_sel` are valid this cycle; sampled only when high.
- `bcd_out`  output  4*NDIG: published digits; digit i at bits [4i+3:4i].
- `bad_digit`  output  NDIG: bit i set when published digit i held a non-decimal pattern.
- `valid`  output  1: one-cycle pulse when `bcd_out`/`bad_digit` update.
- `sel_err`  output  1: one-cycle pulse when a strobe carried a non-one-hot `dig_sel`.

## Operation

- **Pattern map** (`seg` → nibble):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - Any other pattern, including blank 0000000, maps to nibble 4'hF and counts as a bad digit.
- **Capture:** on a strobe with one-hot `dig_sel` selecting digit i, store the nibble in capture slot i and set `seen[i]`.
  - A repeated digit before the frame completes overwrites its slot; no error.
- **Illegal select:** on a strobe with zero or multiple `dig_sel` bits set, ignore the sample. `seen`, capture and counters are unchanged, and `sel_err` pulses.
- **Frame complete:** the accepted strobe that makes `seen` all-ones. The frame is the capture slots with that strobe's nibble merged in. On completion:
  - Clear `seen`, copy the frame to `prev_frame` and set `prev_ok`.
  - `match_cnt` becomes `match_cnt`+1 (saturating at `STABLE`) if `prev_ok` was set and the frame equals `prev_frame`; otherwise it becomes 1.
- **Publish:** occurs on a frame completion when the new `match_cnt` equals `STABLE` and either:
  - no frame has been published since reset, or
  - the frame differs from the current `bcd_out`.
  
  On publish, `bcd_out` takes the frame, `bad_digit[i]` = (nibble i == 4'hF), and `valid` pulses.
- A stable frame identical to `bcd_out` produces no pulse. `STABLE`=1 publishes every changed completed frame.
- **State:**
  - `seen` — NDIG bits.
  - capture slots.
  - `prev_frame`, plus `prev_ok` flag.
  - `match_cnt` — 4 bits.
  - `pub_done` flag.
  - registered outputs.

## Timing

- **Reset** (`rst` high at a rising edge):
  - Outputs: `bcd_out`=0, `bad_digit`=0, `valid`=0, `sel_err`=0.
  - Internal state: `seen`=0, capture slots=0, `prev_frame`=0, `prev_ok`=0, `match_cnt`=0, `pub_done`=0.
  - `rst` has priority over `strobe`. Reset in mid-frame discards the partial frame.
- **Latency:**
  - Strobe high in cycle t → capture/`seen` updated at the edge ending t.
  - If that strobe completes a publishing frame, `bcd_out`, `bad_digit` and `valid` change at the same edge; `valid` is high for exactly cycle t+1.
  - `sel_err`: high in cycle t+1 for a bad strobe in cycle t.
- **Back-to-back strobes** (one per cycle) are supported at full rate with no gaps.
- A frame may complete on consecutive cycles when `NDIG`=1.
- `valid` and `sel_err` are never held more than one cycle unless re-triggered by the next cycle's strobe.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan

- **Stable frame publishes:** `NDIG`=4, `STABLE`=2. Scan digits 0..3 with patterns for 1,2,3,4, twice, one strobe per cycle → no `valid` after the first frame; `valid` one cycle after the 8th strobe; `bcd_out`=16'h4321; `bad_digit`=0.
- **No republish, then change:** repeat the 1234 frame a third time → no `valid`, `bcd_out` holds 16'h4321. Then send frames 9,8,7,6 then 9,8,7,5 → no publish (`match_cnt` resets to 1). Then 9,8,7,5 again → `valid`, `bcd_out`=16'h5789.
- **Invalid pattern:** digit 2 = 0000000 (blank) and digit 3 = 1010101, stable for 2 frames, digits 0/1 = 0 → `bcd_out`=16'hFF00, `bad_digit`=4'b1100.
- **Bad select:** strobe with `dig_sel`=4'b0110 mid-frame → `sel_err` pulses one cycle, frame still needs digits 1 and 2. Strobe with `dig_sel`=0 → same. Out-of-order and duplicate digits (3,0,0,2,1) complete the frame after the 5th strobe using the last digit-0 value.
- **Reset mid-frame:** `rst` asserted after 2 of 4 digits with a strobe in the same cycle → all outputs 0, `seen` cleared. A full stable pair of frames of 0000 after reset publishes `valid` with `bcd_out`=0 (first publish after reset).
- **`STABLE`=1, `NDIG`=1:** alternate strobes 5,5,6 → `valid` after the first strobe (`bcd_out`=5), none after the second, `valid` after the third (`bcd_out`=6).

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers BCD digits from a time-multiplexed 7-segment bus
// and publishes a frame once it has repeated STABLE times in a row.
module seg7_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic                strobe,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     bad_digit,
    output logic                valid,
    output logic                sel_err
);
    localparam logic [3:0] STB = 4'(STABLE);

    logic [NDIG-1:0]   seen_q, seen_d;
    logic [4*NDIG-1:0] cap_q, cap_d;
    logic [4*NDIG-1:0] prev_q, prev_d;
    logic              prev_ok_q, prev_ok_d;
    logic [3:0]        match_q, match_d;
    logic              pub_done_q, pub_done_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic [NDIG-1:0]   bad_q, bad_d;
    logic              valid_q, valid_d;
    logic              sel_err_q, sel_err_d;

    logic [3:0]        nib;
    logic              one_hot, acc, complete, same, publish;
    logic [3:0]        cnt_new;
    logic [4*NDIG-1:0] frame;
    logic [NDIG-1:0]   frame_bad;

    always_comb begin
        case (seg)
            7'b1111110: nib = 4'd0;
            7'b0110000: nib = 4'd1;
            7'b1101101: nib = 4'd2;
            7'b1111001: nib = 4'd3;
            7'b0110011: nib = 4'd4;
            7'b1011011: nib = 4'd5;
            7'b1011111: nib = 4'd6;
            7'b1110000: nib = 4'd7;
            7'b1111111: nib = 4'd8;
            7'b1111011: nib = 4'd9;
            default:    nib = 4'hF;
        endcase
    end

    assign one_hot  = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
    assign acc      = strobe && one_hot;
    assign complete = acc && (&(seen_q | dig_sel));

    // The frame is the capture slots with the current sample merged in.
    always_comb begin
        frame     = cap_q;
        frame_bad = '0;
        for (int i = 0; i < NDIG; i++) begin
            frame[4*i +: 4] = dig_sel[i] ? nib : cap_q[4*i +: 4];
            frame_bad[i]    = (frame[4*i +: 4] == 4'hF);
        end
    end

    assign same    = prev_ok_q && (frame == prev_q);
    assign cnt_new = !same ? 4'd1 : (match_q >= STB) ? STB : match_q + 4'd1;
    assign publish = complete && (cnt_new == STB) && (!pub_done_q || frame != bcd_q);

    always_comb begin
        seen_d     = complete ? '0 : acc ? (seen_q | dig_sel) : seen_q;
        cap_d      = acc ? frame : cap_q;
        prev_d     = complete ? frame : prev_q;
        prev_ok_d  = prev_ok_q || complete;
        match_d    = complete ? cnt_new : match_q;
        pub_done_d = pub_done_q || publish;
        bcd_d      = publish ? frame : bcd_q;
        bad_d      = publish ? frame_bad : bad_q;
        valid_d    = publish;
        sel_err_d  = strobe && !one_hot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_q     <= '0;
            cap_q      <= '0;
            prev_q     <= '0;
            prev_ok_q  <= 1'b0;
            match_q    <= '0;
            pub_done_q <= 1'b0;
            bcd_q      <= '0;
            bad_q      <= '0;
            valid_q    <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            cap_q      <= cap_d;
            prev_q     <= prev_d;
            prev_ok_q  <= prev_ok_d;
            match_q    <= match_d;
            pub_done_q <= pub_done_d;
            bcd_q      <= bcd_d;
            bad_q      <= bad_d;
            valid_q    <= valid_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign bad_digit = bad_q;
    assign valid     = valid_q;
    assign sel_err   = sel_err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: scoreboard bench for a 4-digit/STABLE=2 and a 1-digit/STABLE=1 instance.
module tb_seg7_scan_decoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        strobe;
    logic [15:0] bcd_out;
    logic [3:0]  bad_digit;
    logic        valid, sel_err;

    logic [6:0]  seg1;
    logic [0:0]  sel1;
    logic        stb1;
    logic [3:0]  bcd1;
    logic [0:0]  bad1;
    logic        valid1, sel_err1;

    seg7_scan_decoder #(.NDIG(4), .STABLE(2)) dut0 (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel), .strobe(strobe),
        .bcd_out(bcd_out), .bad_digit(bad_digit), .valid(valid), .sel_err(sel_err));

    seg7_scan_decoder #(.NDIG(1), .STABLE(1)) dut1 (
        .clk(clk), .rst(rst), .seg(seg1), .dig_sel(sel1), .strobe(stb1),
        .bcd_out(bcd1), .bad_digit(bad1), .valid(valid1), .sel_err(sel_err1));

    typedef struct { int c; logic [15:0] bcd; logic [3:0] bd; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int   selq0[$];
    int   selq1[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    function automatic logic [3:0] dec(logic [6:0] s);
        for (int k = 0; k < 10; k++) if (s == pat[k]) return 4'(k);
        return 4'hF;
    endfunction

    // Reference models: a frame is the set of last-seen nibbles per digit; publish
    // when it has been seen STABLE times in a row and differs from what is shown.
    logic [3:0]  mcap [4];
    logic [3:0]  mseen;
    logic [15:0] mlast, mshown;
    bit          mhave, mpub, mpub1;
    int          mrun;
    logic [3:0]  mshown1;

    task automatic mreset();
        mseen = 0; mhave = 0; mpub = 0; mrun = 0; mlast = 0; mshown = 0;
        mpub1 = 0; mshown1 = 0;
        for (int k = 0; k < 4; k++) mcap[k] = 0;
    endtask

    task automatic m0(logic [6:0] s, logic [3:0] sel);
        int i;
        logic [15:0] f;
        exp_t e;
        i = 0;
        if ($countones(sel) != 1) begin
            selq0.push_back(cyc + 1);
            return;
        end
        for (int k = 0; k < 4; k++) if (sel[k]) i = k;
        mcap[i] = dec(s);
        mseen[i] = 1'b1;
        if (mseen != 4'hF) return;
        f = {mcap[3], mcap[2], mcap[1], mcap[0]};
        mseen = 0;
        mrun = (mhave && f == mlast) ? ((mrun >= 2) ? 2 : mrun + 1) : 1;
        mlast = f;
        mhave = 1;
        if (mrun == 2 && (!mpub || f != mshown)) begin
            e.c = cyc + 1;
            e.bcd = f;
            for (int k = 0; k < 4; k++) e.bd[k] = (mcap[k] == 4'hF);
            q0.push_back(e);
            mshown = f;
            mpub = 1;
        end
    endtask

    task automatic m1(logic [6:0] s, logic sel);
        exp_t e;
        if (!sel) begin
            selq1.push_back(cyc + 1);
            return;
        end
        if (!mpub1 || dec(s) != mshown1) begin
            e.c = cyc + 1;
            e.bcd = {12'h0, dec(s)};
            e.bd = {3'b0, dec(s) == 4'hF};
            q1.push_back(e);
            mshown1 = dec(s);
            mpub1 = 1;
        end
    endtask

    task automatic step(logic [6:0] s, logic [3:0] sel, bit st,
                        logic [6:0] s1v = 0, logic s1sel = 0, bit st1 = 0);
        seg = s; dig_sel = sel; strobe = st;
        seg1 = s1v; sel1 = s1sel; stb1 = st1;
        if (st) m0(s, sel);
        if (st1) m1(s1v, s1sel);
        @(posedge clk);
        #1;
        strobe = 0; stb1 = 0;
    endtask

    task automatic do_reset(bit st = 0);
        rst = 1; strobe = st; stb1 = st;
        seg = pat[3]; dig_sel = 4'b0100; seg1 = pat[3]; sel1 = 1'b1;
        @(posedge clk);
        #1;
        rst = 0; strobe = 0; stb1 = 0;
        mreset();
        chk("rst_bcd", bcd_out, 0);
        chk("rst_bad", bad_digit, 0);
        chk("rst_valid", valid, 0);
        chk("rst_sel_err", sel_err, 0);
        chk("rst_bcd1", bcd1, 0);
        chk("rst_valid1", valid1, 0);
    endtask

    task automatic frame4(int d0, int d1, int d2, int d3);
        step(pat[d0], 4'b0001, 1);
        step(pat[d1], 4'b0010, 1);
        step(pat[d2], 4'b0100, 1);
        step(pat[d3], 4'b1000, 1);
    endtask

    // Monitor: expired expectations are reported before the current output is matched.
    always @(negedge clk) begin
        exp_t e;
        int c;
        while (q0.size() > 0 && q0[0].c < cyc) begin
            e = q0.pop_front();
            chk("valid0_missing", cyc, e.c);
        end
        while (selq0.size() > 0 && selq0[0] < cyc) begin
            c = selq0.pop_front();
            chk("sel_err0_missing", cyc, c);
        end
        while (q1.size() > 0 && q1[0].c < cyc) begin
            e = q1.pop_front();
            chk("valid1_missing", cyc, e.c);
        end
        while (selq1.size() > 0 && selq1[0] < cyc) begin
            c = selq1.pop_front();
            chk("sel_err1_missing", cyc, c);
        end
        if (valid) begin
            if (q0.size() == 0) chk("valid0_extra", valid, 0);
            else begin
                e = q0.pop_front();
                chk("valid0_cycle", cyc, e.c);
                chk("bcd_out", bcd_out, e.bcd);
                chk("bad_digit", bad_digit, e.bd);
            end
        end
        if (sel_err) begin
            if (selq0.size() == 0) chk("sel_err0_extra", sel_err, 0);
            else begin
                c = selq0.pop_front();
                chk("sel_err0_cycle", cyc, c);
            end
        end
        if (valid1) begin
            if (q1.size() == 0) chk("valid1_extra", valid1, 0);
            else begin
                e = q1.pop_front();
                chk("valid1_cycle", cyc, e.c);
                chk("bcd1", bcd1, e.bcd);
                chk("bad1", bad1, e.bd);
            end
        end
        if (sel_err1) begin
            if (selq1.size() == 0) chk("sel_err1_extra", sel_err1, 0);
            else begin
                c = selq1.pop_front();
                chk("sel_err1_cycle", cyc, c);
            end
        end
    end

    logic [6:0] fset [3][4];
    logic [3:0] bs;

    initial begin
        rst = 1; strobe = 0; stb1 = 0; seg = 0; dig_sel = 0; seg1 = 0; sel1 = 0;
        mreset();
        @(posedge clk);
        #1;
        do_reset();

        frame4(1, 2, 3, 4);
        frame4(1, 2, 3, 4);
        step(0, 0, 0);
        chk("stable_bcd", bcd_out, 16'h4321);
        chk("stable_bad", bad_digit, 4'b0000);

        frame4(1, 2, 3, 4);
        frame4(9, 8, 7, 6);
        frame4(9, 8, 7, 5);
        step(0, 0, 0);
        chk("hold_bcd", bcd_out, 16'h4321);
        frame4(9, 8, 7, 5);
        step(0, 0, 0);
        chk("change_bcd", bcd_out, 16'h5789);

        for (int r = 0; r < 2; r++) begin
            step(pat[0], 4'b0001, 1);
            step(pat[0], 4'b0010, 1);
            step(7'b0000000, 4'b0100, 1);
            step(7'b1010101, 4'b1000, 1);
        end
        step(0, 0, 0);
        chk("invalid_bcd", bcd_out, 16'hFF00);
        chk("invalid_bad", bad_digit, 4'b1100);

        for (int r = 0; r < 2; r++) begin
            step(pat[4], 4'b1000, 1);
            step(pat[7], 4'b0001, 1);
            step(pat[1], 4'b0110, 1);
            step(pat[8], 4'b0001, 1);
            step(pat[2], 4'b0000, 1);
            step(pat[6], 4'b0100, 1);
            step(pat[3], 4'b0010, 1);
        end
        step(0, 0, 0);
        chk("ooo_bcd", bcd_out, 16'h4638);

        step(pat[1], 4'b0001, 1);
        step(pat[2], 4'b0010, 1);
        do_reset(1);
        frame4(0, 0, 0, 0);
        frame4(0, 0, 0, 0);

        step(0, 0, 0, pat[5], 1, 1);
        step(0, 0, 0, pat[5], 1, 1);
        step(0, 0, 0, pat[6], 1, 1);
        step(0, 0, 0, pat[6], 0, 1);
        step(0, 0, 0);
        chk("one_digit_bcd", bcd1, 4'h6);

        for (int n = 0; n < 3; n++)
            for (int k = 0; k < 4; k++)
                fset[n][k] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pat[$urandom_range(0, 9)];
        for (int n = 0; n < 150; n++) begin
            int f;
            f = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) fset[f][$urandom_range(0, 3)] = pat[$urandom_range(0, 9)];
            for (int r = 0; r < int'($urandom_range(1, 3)); r++)
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 60) == 0) do_reset($urandom_range(0, 1) == 1);
                    if ($urandom_range(0, 12) == 0) begin
                        do bs = 4'($urandom); while ($countones(bs) == 1);
                        step(pat[$urandom_range(0, 9)], bs, 1);
                    end
                    if ($urandom_range(0, 4) == 0) step(pat[0], 4'b1111, 0);
                    step(fset[f][k], 4'(1 << k), 1,
                         ($urandom_range(0, 5) == 0) ? 7'($urandom) : pat[$urandom_range(0, 2)],
                         $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
                end
        end

        repeat (3) step(0, 0, 0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("selq0_drained", selq0.size(), 0);
        chk("selq1_drained", selq1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
